fetch_unit: RTL and testbench

- Instruction fetch front-end of the RV32I core.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {instr, pc, pc+4} to decode. The instr field feeds the immediate extender and register-file address decode.
- Accepts redirects (branch/jump target = pc + extended immediate), flushes buffered work and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front-end with credit-limited requests, in-order response FIFO and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;
  logic [CW:0]   used;
  logic          boot_q, req_fire, push, pop;
  // credit counts buffered plus in-flight work; a same-cycle pop frees nothing
  assign used           = {1'b0, occ_q} + {1'b0, outst_q};
  assign imem_req_valid = rst_n && !boot_q && (used < CW1'(FIFO_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = rst_n && (occ_q != '0) && !redirect_valid;
  assign instr          = data_q[rd_q];
  assign instr_pc       = pc_q[rd_q];
  assign instr_pc_plus4 = pc_q[rd_q] + 32'd4;
  assign target         = {redirect_pc[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign pop            = instr_valid && instr_ready;
  // next state: redirect flushes the buffer and turns every in-flight response into a drop
  always_comb begin
    outst_d    = outst_q + (req_fire ? CW'(1) : '0) - (imem_rsp_valid ? CW'(1) : '0);
    fetch_pc_d = redirect_valid ? target : fetch_pc_q + (req_fire ? 32'd4 : 32'd0);
    rsp_pc_d   = redirect_valid ? target : rsp_pc_q + (push ? 32'd4 : 32'd0);
    occ_d      = redirect_valid ? '0 : occ_q + (push ? CW'(1) : '0) - (pop ? CW'(1) : '0);
    drop_d     = redirect_valid ? outst_d : drop_q - ((imem_rsp_valid && drop_q != '0) ? CW'(1) : '0);
    rd_d       = redirect_valid ? '0 : rd_q + (pop ? AW'(1) : '0);
    wr_d       = redirect_valid ? '0 : wr_q + (push ? AW'(1) : '0);
  end
  // control state; boot_q suppresses requests for the first cycle out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      boot_q     <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      boot_q     <= 1'b0;
    end
  end
  // buffer storage needs no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= imem_rsp_data;
      pc_q[wr_q]   <= rsp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-programmable memory model
module tb_fetch_unit;
  localparam logic [31:0] RPC_A = 32'h0000_0000;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, req_ready, rsp_valid, redirect, instr_ready;
  logic [31:0] rsp_data, redirect_pc;
  logic        a_req_valid, b_req_valid, a_instr_valid, b_instr_valid;
  logic [31:0] a_req_addr, b_req_addr, a_instr, b_instr, a_pc, b_pc, a_p4, b_p4;
  logic        m_req_valid, m_instr_valid;
  logic [31:0] m_req_addr, m_instr, m_pc, m_p4;
  bit          sel;
  int          total, bad, cyc, lat, n_req, n_instr;
  logic [31:0] mdl_addr;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$], req_log[$], pc_log[$], p4_log[$], d_log[$];
  fetch_unit #(.RESET_PC(RPC_A), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(a_req_valid), .imem_req_ready(req_ready),
    .imem_req_addr(a_req_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect), .redirect_pc(redirect_pc), .instr_valid(a_instr_valid),
    .instr_ready(instr_ready), .instr(a_instr), .instr_pc(a_pc), .instr_pc_plus4(a_p4));
  fetch_unit #(.RESET_PC(RPC_B), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(b_req_valid), .imem_req_ready(req_ready),
    .imem_req_addr(b_req_addr), .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect), .redirect_pc(redirect_pc), .instr_valid(b_instr_valid),
    .instr_ready(instr_ready), .instr(b_instr), .instr_pc(b_pc), .instr_pc_plus4(b_p4));
  assign m_req_valid   = sel ? b_req_valid   : a_req_valid;
  assign m_req_addr    = sel ? b_req_addr    : a_req_addr;
  assign m_instr_valid = sel ? b_instr_valid : a_instr_valid;
  assign m_instr       = sel ? b_instr       : a_instr;
  assign m_pc          = sel ? b_pc          : a_pc;
  assign m_p4          = sel ? b_p4          : a_p4;

  task automatic drive();
    logic [31:0] e;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_q[0].addr ^ XMASK;
      void'(mem_q.pop_front());
    end
    #1;
    if (!rst_n) begin
      mem_q.delete();
      exp_q.delete();
      mdl_addr = sel ? RPC_B : RPC_A;
    end else begin
      if (m_req_valid && req_ready) begin
        n_req++;
        req_log.push_back(m_req_addr);
        total++;
        if (m_req_addr !== mdl_addr) begin
          bad++;
          $display("FAIL req_addr: got %h want %h", m_req_addr, mdl_addr);
        end
        mem_q.push_back('{addr: m_req_addr, due: cyc + lat});
        exp_q.push_back(mdl_addr);
        mdl_addr += 32'd4;
        total++;
        if (exp_q.size() > 2) begin
          bad++;
          $display("FAIL credit: outstanding work %0d exceeds 2", exp_q.size());
        end
      end
      if (m_instr_valid && instr_ready) begin
        n_instr++;
        pc_log.push_back(m_pc);
        p4_log.push_back(m_p4);
        d_log.push_back(m_instr);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL instr_unexpected: got pc %h, none expected", m_pc);
        end else begin
          e = exp_q.pop_front();
          if (m_pc !== e || m_instr !== (e ^ XMASK) || m_p4 !== e + 32'd4) begin
            bad++;
            $display("FAIL instr: got pc %h data %h p4 %h want pc %h data %h p4 %h",
                     m_pc, m_instr, m_p4, e, e ^ XMASK, e + 32'd4);
          end
        end
      end
      if (redirect) begin
        exp_q.delete();
        mdl_addr = {redirect_pc[31:2], 2'b00};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pc_log.delete();
    p4_log.delete();
    d_log.delete();
    n_req   = 0;
    n_instr = 0;
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    redirect = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_instr(input string name, input int budget);
    for (int i = 0; i < budget && pc_log.size() == 0; i++) step();
    if (pc_log.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no instruction within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; lat = 1; req_ready = 1'b1; instr_ready = 1'b1; rst_n = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive();
      total++;
      if (m_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", m_req_valid); end
      tick();
    end
    rst_n = 1'b1;
    clear_logs();
    drive();
    total++;
    if (m_instr_valid !== 1'b0) begin bad++; $display("FAIL boot_instr_valid: got %b want 0", m_instr_valid); end
    total++;
    if (m_req_valid !== 1'b0) begin bad++; $display("FAIL boot_req_valid: got %b want 0", m_req_valid); end
    tick();
    drive();
    total++;
    if (m_req_valid !== 1'b1 || m_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL first_req: got valid %b addr %h want 1 00000000", m_req_valid, m_req_addr);
    end
    tick();
  endtask

  task automatic test_stream();
    lat = 1; instr_ready = 1'b1;
    do_reset(2);
    repeat (15) step();
    total++;
    if (n_instr < 7) begin bad++; $display("FAIL stream_count: got %0d want >= 7", n_instr); end
    foreach (pc_log[i]) begin
      total++;
      if (pc_log[i] !== 32'(i * 4) || p4_log[i] !== 32'(i * 4 + 4)) begin
        bad++;
        $display("FAIL stream_order[%0d]: got pc %h p4 %h want %h %h", i, pc_log[i], p4_log[i], 32'(i * 4), 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; instr_ready = 1'b0;
    do_reset(2);
    repeat (10) step();
    total++;
    if (n_req != 2) begin bad++; $display("FAIL stall_reqs: got %0d want 2", n_req); end
    drive();
    total++;
    if (m_req_valid !== 1'b0 || m_instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_state: got req %b instr %b want 0 1", m_req_valid, m_instr_valid);
    end
    tick();
    clear_logs();
    instr_ready = 1'b1;
    repeat (10) step();
    total++;
    if (pc_log.size() < 3 || pc_log[0] !== 32'h0 || pc_log[1] !== 32'h4 || pc_log[2] !== 32'h8) begin
      bad++;
      $display("FAIL release_order: got %0d instrs first %h want 0,4,8", pc_log.size(), pc_log.size() ? pc_log[0] : 32'hx);
    end
    total++;
    if (req_log.size() == 0 || req_log[0] !== 32'h8) begin
      bad++;
      $display("FAIL resume_addr: got %h want 00000008", req_log.size() ? req_log[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_inflight();
    lat = 3; instr_ready = 1'b1;
    do_reset(2);
    repeat (3) step();
    total++;
    if (n_req != 2) begin bad++; $display("FAIL inflight_reqs: got %0d want 2", n_req); end
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    drive();
    total++;
    if (m_req_valid !== 1'b0) begin bad++; $display("FAIL redirect_req: got %b want 0", m_req_valid); end
    tick();
    redirect = 1'b0;
    clear_logs();
    wait_instr("inflight", 20);
    if (pc_log.size() != 0) begin
      total++;
      if (pc_log[0] !== 32'h100 || d_log[0] !== 32'hA5A5_0100) begin
        bad++;
        $display("FAIL inflight_first: got pc %h data %h want 00000100 a5a50100", pc_log[0], d_log[0]);
      end
    end
  endtask

  task automatic test_redirect_same_cycle();
    lat = 1; instr_ready = 1'b0;
    do_reset(2);
    repeat (3) step();
    total++;
    if (m_instr_valid !== 1'b1) begin bad++; $display("FAIL pre_redirect_valid: got %b want 1", m_instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h0000_0206; instr_ready = 1'b1;
    drive();
    total++;
    if (m_instr_valid !== 1'b0 || rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_valid: got instr_valid %b rsp %b want 0 1", m_instr_valid, rsp_valid);
    end
    tick();
    redirect = 1'b0;
    clear_logs();
    wait_instr("same_cycle", 15);
    total++;
    if (req_log.size() == 0 || req_log[0] !== 32'h204) begin
      bad++;
      $display("FAIL same_cycle_req: got %h want 00000204", req_log.size() ? req_log[0] : 32'hx);
    end
    if (pc_log.size() != 0) begin
      total++;
      if (pc_log[0] !== 32'h204) begin bad++; $display("FAIL same_cycle_pc: got %h want 00000204", pc_log[0]); end
    end
  endtask

  task automatic test_wrap();
    int k;
    sel = 1'b1; lat = 1; instr_ready = 1'b1;
    do_reset(2);
    repeat (12) step();
    total++;
    if (req_log.size() < 3 || req_log[0] !== 32'hFFFF_FFF8 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_addrs: got %0d reqs first %h want fffffff8,fffffffc,00000000", req_log.size(), req_log.size() ? req_log[0] : 32'hx);
    end
    k = -1;
    foreach (pc_log[i]) if (pc_log[i] === 32'hFFFF_FFFC) k = i;
    total++;
    if (k < 0 || p4_log[k] !== 32'h0) begin
      bad++;
      $display("FAIL wrap_plus4: got %h want 00000000", k < 0 ? 32'hx : p4_log[k]);
    end
    instr_ready = 1'b0;
    repeat (3) step();
    do_reset(1);
    instr_ready = 1'b1;
    drive();
    total++;
    if (m_instr_valid !== 1'b0 || m_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_boot: got instr %b req %b want 0 0", m_instr_valid, m_req_valid);
    end
    tick();
    repeat (6) step();
    total++;
    if (req_log.size() == 0 || req_log[0] !== RPC_B || pc_log.size() == 0 || pc_log[0] !== RPC_B) begin
      bad++;
      $display("FAIL midreset_restart: got req %h pc %h want fffffff8",
               req_log.size() ? req_log[0] : 32'hx, pc_log.size() ? pc_log[0] : 32'hx);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; lat = 1; sel = 1'b0;
    rst_n = 1'b0; req_ready = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    rsp_valid = 1'b0; rsp_data = '0; mdl_addr = RPC_A;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
